// File: rtl/hazard_pkg.sv
// Shared encodings for the pipeline hazard controller: FSM states, the load writeback select,
// and the default mul/div timeout.
package hazard_pkg;

  typedef enum logic [1:0] {
    ST_RUN         = 2'd0,
    ST_LOAD_STALL  = 2'd1,
    ST_MULDIV_WAIT = 2'd2,
    ST_FLUSH       = 2'd3
  } hz_state_e;

  localparam logic [1:0] SEL_DATA_LOAD          = 2'd3;
  localparam int         MULDIV_TIMEOUT_DEFAULT = 40;

endpackage

// File: rtl/hz_perf_counter.sv
// Saturating 32-bit event counter: adds one per cycle with inc high, holds at all-ones.
// Synchronous active-high reset clears it.
module hz_perf_counter (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  output logic [31:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= 32'd0;
    end else if (inc && (count != 32'hFFFF_FFFF)) begin
      count <= count + 32'd1;
    end
  end

endmodule

// File: rtl/hazard_controller.sv
// Pipeline hazard FSM: load-use stall, mul/div wait with timeout, taken-branch flush.
// Optional stall-cycle counter (stall_cnt port) is built only when HAZARD_PERF_CNT_EN is defined.
module hazard_controller
  import hazard_pkg::*;
#(
  parameter int MULDIV_TIMEOUT = MULDIV_TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rsA,
  input  logic [4:0]  id_rsB,
  input  logic        id_is_jalr,
  input  logic        id_is_branch,
  input  logic [4:0]  exe_rd,
  input  logic        exe_wr_en,
  input  logic [1:0]  exe_sel_data,
  input  logic        exe_muldiv_start,
  input  logic        muldiv_done,
  input  logic        exe_branch_taken,
  output logic        stall_if,
  output logic        stall_id,
  output logic        stall_exe,
  output logic        flush_id,
  output logic        flush_exe,
  output logic [1:0]  hz_state,
  output logic        hz_err
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] stall_cnt
`endif
);

  localparam int CNT_W = ($clog2(MULDIV_TIMEOUT) > 8) ? $clog2(MULDIV_TIMEOUT) : 8;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(MULDIV_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  hz_state_e        state;
  hz_state_e        state_nxt;
  logic [CNT_W-1:0] to_cnt;
  logic             load_use;
  logic             err_set;
  logic             s_if, s_id, s_exe, f_id, f_exe;

  // Only branch/JALR consume operands in ID; ALU consumers are covered by forwarding.
  assign load_use = (exe_sel_data == SEL_DATA_LOAD) && exe_wr_en && (exe_rd != 5'd0) &&
                    (id_is_jalr || id_is_branch) &&
                    ((id_rsA == exe_rd) || (id_is_branch && (id_rsB == exe_rd)));

  // Stalls and flushes must act in the cycle the event is seen, so they decode state + inputs.
  always_comb begin
    state_nxt = state;
    err_set   = 1'b0;
    s_if      = 1'b0;
    s_id      = 1'b0;
    s_exe     = 1'b0;
    f_id      = 1'b0;
    f_exe     = 1'b0;
    unique case (state)
      ST_RUN: begin
        if (exe_branch_taken) begin
          f_id      = 1'b1;
          f_exe     = 1'b1;
          state_nxt = ST_FLUSH;
        end else if (exe_muldiv_start) begin
          s_if      = 1'b1;
          s_id      = 1'b1;
          s_exe     = 1'b1;
          state_nxt = ST_MULDIV_WAIT;
        end else if (load_use) begin
          s_if      = 1'b1;
          s_id      = 1'b1;
          f_exe     = 1'b1;
          state_nxt = ST_LOAD_STALL;
        end
      end
      ST_LOAD_STALL: state_nxt = ST_RUN;
      ST_MULDIV_WAIT: begin
        if (muldiv_done) begin
          state_nxt = ST_RUN;
        end else if (to_cnt == TO_LAST) begin
          err_set   = 1'b1;
          state_nxt = ST_RUN;
        end else begin
          s_if  = 1'b1;
          s_id  = 1'b1;
          s_exe = 1'b1;
        end
      end
      ST_FLUSH: state_nxt = ST_RUN;
    endcase
  end

  assign stall_if  = s_if  && !rst;
  assign stall_id  = s_id  && !rst;
  assign stall_exe = s_exe && !rst;
  assign flush_id  = f_id  && !rst;
  assign flush_exe = f_exe && !rst;
  assign hz_state  = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_RUN;
      to_cnt <= '0;
      hz_err <= 1'b0;
    end else begin
      state <= state_nxt;
      if ((state == ST_RUN) && exe_muldiv_start && !exe_branch_taken) begin
        to_cnt <= '0;
      end else if ((state == ST_MULDIV_WAIT) && (to_cnt != CNT_MAX)) begin
        to_cnt <= to_cnt + 1'b1;
      end
      if (err_set) begin
        hz_err <= 1'b1;
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  hz_perf_counter u_perf (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_if),
    .count (stall_cnt)
  );
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Directed scoreboard bench for hazard_controller: default instance plus a MULDIV_TIMEOUT=4 instance.
// Expected per-cycle outputs are queued when inputs are driven and compared when sampled.
module tb_hazard_controller;
  import hazard_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rsA, id_rsB, exe_rd;
  logic       id_is_jalr, id_is_branch, exe_wr_en;
  logic [1:0] exe_sel_data;
  logic       exe_muldiv_start, muldiv_done, exe_branch_taken;
  logic       t_start, t_done;

  logic       stall_if, stall_id, stall_exe, flush_id, flush_exe, hz_err;
  logic [1:0] hz_state;
  logic       t_stall_if, t_stall_id, t_stall_exe, t_flush_id, t_flush_exe, t_hz_err;
  logic [1:0] t_hz_state;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt, t_stall_cnt;
`endif

  typedef struct packed {
    logic       inst;
    logic [4:0] outs;
    logic [1:0] st;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   exp_stall = 0;

  always #5 clk = ~clk;

  hazard_controller dut (
    .clk(clk), .rst(rst), .id_rsA(id_rsA), .id_rsB(id_rsB),
    .id_is_jalr(id_is_jalr), .id_is_branch(id_is_branch), .exe_rd(exe_rd),
    .exe_wr_en(exe_wr_en), .exe_sel_data(exe_sel_data),
    .exe_muldiv_start(exe_muldiv_start), .muldiv_done(muldiv_done),
    .exe_branch_taken(exe_branch_taken), .stall_if(stall_if), .stall_id(stall_id),
    .stall_exe(stall_exe), .flush_id(flush_id), .flush_exe(flush_exe),
    .hz_state(hz_state), .hz_err(hz_err)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  hazard_controller #(.MULDIV_TIMEOUT(4)) dut_to (
    .clk(clk), .rst(rst), .id_rsA(id_rsA), .id_rsB(id_rsB),
    .id_is_jalr(id_is_jalr), .id_is_branch(id_is_branch), .exe_rd(exe_rd),
    .exe_wr_en(exe_wr_en), .exe_sel_data(exe_sel_data),
    .exe_muldiv_start(t_start), .muldiv_done(t_done),
    .exe_branch_taken(exe_branch_taken), .stall_if(t_stall_if), .stall_id(t_stall_id),
    .stall_exe(t_stall_exe), .flush_id(t_flush_id), .flush_exe(t_flush_exe),
    .hz_state(t_hz_state), .hz_err(t_hz_err)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cnt(t_stall_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [1:0] sel, input logic wr, input logic [4:0] rd,
                       input logic jalr, input logic br, input logic [4:0] ra,
                       input logic [4:0] rb, input logic start, input logic done,
                       input logic taken);
    exe_sel_data     = sel;
    exe_wr_en        = wr;
    exe_rd           = rd;
    id_is_jalr       = jalr;
    id_is_branch     = br;
    id_rsA           = ra;
    id_rsB           = rb;
    exe_muldiv_start = start;
    muldiv_done      = done;
    exe_branch_taken = taken;
  endtask

  task automatic clr();
    drive(2'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // outs order: {stall_if, stall_id, stall_exe, flush_id, flush_exe}
  task automatic cyc(input string tag, input logic inst, input logic [4:0] outs,
                     input logic [1:0] st, input logic err);
    exp_t e;
    exp_t p;
    logic [4:0] got_outs;
    e.inst = inst;
    e.outs = outs;
    e.st   = st;
    e.err  = err;
    exp_q.push_back(e);
    #2;
    p = exp_q.pop_front();
    if (p.inst) begin
      got_outs = {t_stall_if, t_stall_id, t_stall_exe, t_flush_id, t_flush_exe};
      check({tag, "_outs"}, {27'd0, got_outs}, {27'd0, p.outs});
      check({tag, "_state"}, {30'd0, t_hz_state}, {30'd0, p.st});
      check({tag, "_err"}, {31'd0, t_hz_err}, {31'd0, p.err});
    end else begin
      got_outs = {stall_if, stall_id, stall_exe, flush_id, flush_exe};
      check({tag, "_outs"}, {27'd0, got_outs}, {27'd0, p.outs});
      check({tag, "_state"}, {30'd0, hz_state}, {30'd0, p.st});
      check({tag, "_err"}, {31'd0, hz_err}, {31'd0, p.err});
      if (rst) exp_stall = 0;
      else if (p.outs[4]) exp_stall++;
    end
    @(negedge clk);
  endtask

  task automatic check_cnt(input string tag);
`ifdef HAZARD_PERF_CNT_EN
    check(tag, stall_cnt, exp_stall);
`else
    n_checks = n_checks + 0;
`endif
  endtask

  localparam logic [1:0] RUN = 2'd0, LS = 2'd1, MW = 2'd2, FL = 2'd3;

  initial begin
    rst = 1'b1; t_start = 1'b0; t_done = 1'b0;
    clr();
    @(negedge clk);
    cyc("rst_hold", 0, 5'b00000, RUN, 0);
    rst = 1'b0;
    cyc("rst_state", 0, 5'b00000, RUN, 0);
    check_cnt("rst_cnt");

    drive(2'd3, 1, 5'd5, 1, 0, 5'd5, 5'd0, 0, 0, 0);
    cyc("lu_stall", 0, 5'b11001, RUN, 0);
    cyc("lu_hold", 0, 5'b00000, LS, 0);
    clr();
    cyc("lu_back", 0, 5'b00000, RUN, 0);
    drive(2'd3, 1, 5'd7, 0, 1, 5'd2, 5'd7, 0, 0, 0);
    cyc("lu_br_rsb", 0, 5'b11001, RUN, 0);
    clr();
    cyc("lu_br_hold", 0, 5'b00000, LS, 0);

    drive(2'd3, 1, 5'd5, 0, 0, 5'd5, 5'd0, 0, 0, 0);
    cyc("nh_nojb", 0, 5'b00000, RUN, 0);
    drive(2'd3, 1, 5'd0, 1, 0, 5'd0, 5'd0, 0, 0, 0);
    cyc("nh_rd0", 0, 5'b00000, RUN, 0);
    drive(2'd0, 1, 5'd5, 1, 0, 5'd5, 5'd0, 0, 0, 0);
    cyc("nh_alu", 0, 5'b00000, RUN, 0);
    drive(2'd3, 0, 5'd5, 1, 0, 5'd5, 5'd0, 0, 0, 0);
    cyc("nh_nowr", 0, 5'b00000, RUN, 0);
    drive(2'd3, 1, 5'd5, 1, 0, 5'd2, 5'd5, 0, 0, 0);
    cyc("nh_jalr_rsb", 0, 5'b00000, RUN, 0);

    drive(2'd3, 1, 5'd5, 1, 0, 5'd5, 5'd0, 1, 0, 1);
    cyc("pri_flush", 0, 5'b00011, RUN, 0);
    drive(2'd3, 1, 5'd5, 1, 0, 5'd5, 5'd0, 0, 0, 0);
    cyc("pri_guard", 0, 5'b00000, FL, 0);
    clr();
    cyc("pri_back", 0, 5'b00000, RUN, 0);

    rst = 1'b1;
    cyc("rst2", 0, 5'b00000, RUN, 0);
    rst = 1'b0;
    check_cnt("rst2_cnt");
    drive(2'd0, 0, 5'd0, 0, 0, 5'd0, 5'd0, 1, 0, 0);
    cyc("md_start", 0, 5'b11100, RUN, 0);
    clr();
    cyc("md_w1", 0, 5'b11100, MW, 0);
    drive(2'd3, 1, 5'd5, 1, 0, 5'd5, 5'd0, 1, 0, 1);
    cyc("md_ignore", 0, 5'b11100, MW, 0);
    clr();
    cyc("md_w3", 0, 5'b11100, MW, 0);
    cyc("md_w4", 0, 5'b11100, MW, 0);
    drive(2'd0, 0, 5'd0, 0, 0, 5'd0, 5'd0, 0, 1, 0);
    cyc("md_done", 0, 5'b00000, MW, 0);
    cyc("md_run_done", 0, 5'b00000, RUN, 0);
    clr();
    cyc("md_run", 0, 5'b00000, RUN, 0);
    check_cnt("md_cnt");

    drive(2'd0, 0, 5'd0, 0, 0, 5'd0, 5'd0, 1, 0, 0);
    cyc("rw_start", 0, 5'b11100, RUN, 0);
    clr();
    cyc("rw_w1", 0, 5'b11100, MW, 0);
    rst = 1'b1;
    cyc("rw_rst", 0, 5'b00000, MW, 0);
    rst = 1'b0;
    check_cnt("rw_cnt");
    cyc("rw_after", 0, 5'b00000, RUN, 0);

    drive(2'd3, 1, 5'd5, 1, 0, 5'd5, 5'd0, 0, 0, 0);
    cyc("rl_stall", 0, 5'b11001, RUN, 0);
    rst = 1'b1;
    cyc("rl_rst", 0, 5'b00000, LS, 0);
    rst = 1'b0;
    clr();
    cyc("rl_after", 0, 5'b00000, RUN, 0);

    t_start = 1'b1;
    cyc("to_start", 1, 5'b11100, RUN, 0);
    t_start = 1'b0;
    cyc("to_w0", 1, 5'b11100, MW, 0);
    cyc("to_w1", 1, 5'b11100, MW, 0);
    cyc("to_w2", 1, 5'b11100, MW, 0);
    cyc("to_exit", 1, 5'b00000, MW, 0);
    cyc("to_err", 1, 5'b00000, RUN, 1);
    for (int i = 0; i < 3; i++) cyc("to_sticky", 1, 5'b00000, RUN, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
